// File: rtl/lsu_frontend.sv
// lsu_frontend: per-thread load/store front end issuing one memory request per LDR/STR.
// Ports:
//   clk, reset (async, active-low)        clock and reset
//   enable, core_state                     thread active, core phase (REQUEST=3'b011, UPDATE=3'b110)
//   decoded_mem_read_enable/write_enable   decoded LDR / STR
//   rs, rt                                 address operand, store data operand
//   mem_read_valid/address                 read request to memory controller
//   mem_write_valid/address/data           write request to memory controller
//   mem_ready, mem_read_data               controller completion pulse and read return data
//   lsu_state, lsu_out, lsu_error          FSM state, last load result, sticky timeout flag
// Optional: define LSU_TIMEOUT_EN to abort WAITING after TIMEOUT_CYCLES cycles.
module lsu_frontend #(
   parameter int ADDR_BITS      = 8,
   parameter int DATA_BITS      = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [2:0]           core_state,
   input  logic                 decoded_mem_read_enable,
   input  logic                 decoded_mem_write_enable,
   input  logic [DATA_BITS-1:0] rs,
   input  logic [DATA_BITS-1:0] rt,
   output logic                 mem_read_valid,
   output logic [ADDR_BITS-1:0] mem_read_address,
   output logic                 mem_write_valid,
   output logic [ADDR_BITS-1:0] mem_write_address,
   output logic [DATA_BITS-1:0] mem_write_data,
   input  logic                 mem_ready,
   input  logic [DATA_BITS-1:0] mem_read_data,
   output logic [1:0]           lsu_state,
   output logic [DATA_BITS-1:0] lsu_out,
   output logic                 lsu_error
);
   typedef enum logic [1:0] {IDLE = 2'b00, REQUESTING = 2'b01, WAITING = 2'b10, DONE = 2'b11} state_t;
   localparam logic [2:0] REQUEST = 3'b011;
   localparam logic [2:0] UPDATE  = 3'b110;
   state_t state, state_d;
   logic rv_d, wv_d, timeout, err_d;
   logic [ADDR_BITS-1:0] ra_d, wa_d;
   logic [DATA_BITS-1:0] wd_d, out_d;
`ifdef LSU_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CW-1:0] cnt, cnt_d;
   logic err;
   assign timeout   = (state == WAITING) && (cnt == CW'(TIMEOUT_CYCLES - 1));
   assign lsu_error = err;
`else
   assign timeout   = 1'b0;
   assign lsu_error = 1'b0;
`endif
   assign lsu_state = state;
   always_comb begin
      state_d = state;
      rv_d    = mem_read_valid;
      wv_d    = mem_write_valid;
      ra_d    = mem_read_address;
      wa_d    = mem_write_address;
      wd_d    = mem_write_data;
      out_d   = lsu_out;
      err_d   = lsu_error;
      case (state)
         IDLE: begin
            // The request is launched on the transition so it is visible during REQUESTING;
            // read wins when both decodes are set.
            if (enable && core_state == REQUEST && (decoded_mem_read_enable || decoded_mem_write_enable)) begin
               state_d = REQUESTING;
               rv_d    = decoded_mem_read_enable;
               wv_d    = !decoded_mem_read_enable;
               if (decoded_mem_read_enable) ra_d = rs[ADDR_BITS-1:0];
               else begin
                  wa_d = rs[ADDR_BITS-1:0];
                  wd_d = rt;
               end
            end
         end
         REQUESTING: state_d = WAITING;
         WAITING: begin
            if (mem_ready || timeout) begin
               state_d = DONE;
               rv_d    = 1'b0;
               wv_d    = 1'b0;
               if (mem_ready && mem_read_valid) out_d = mem_read_data;
               if (!mem_ready) err_d = 1'b1;
            end
         end
         default: state_d = (core_state == UPDATE) ? IDLE : DONE;
      endcase
   end
`ifdef LSU_TIMEOUT_EN
   assign cnt_d = (state == WAITING) ? cnt + 1'b1 : '0;
`endif
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= IDLE;
         mem_read_valid    <= 1'b0;
         mem_write_valid   <= 1'b0;
         mem_read_address  <= '0;
         mem_write_address <= '0;
         mem_write_data    <= '0;
         lsu_out           <= '0;
`ifdef LSU_TIMEOUT_EN
         cnt               <= '0;
         err               <= 1'b0;
`endif
      end else begin
         state             <= state_d;
         mem_read_valid    <= rv_d;
         mem_write_valid   <= wv_d;
         mem_read_address  <= ra_d;
         mem_write_address <= wa_d;
         mem_write_data    <= wd_d;
         lsu_out           <= out_d;
`ifdef LSU_TIMEOUT_EN
         cnt               <= cnt_d;
         err               <= err_d;
`endif
      end
   end
endmodule

// File: tb/tb_lsu_frontend.sv
// tb_lsu_frontend: directed self-checking bench for lsu_frontend (load, store, both-decode,
// stray ready, async reset mid-wait, enable handling, and timeout when LSU_TIMEOUT_EN is defined).
module tb_lsu_frontend;
   logic       clk = 0;
   logic       reset;
   logic       enable;
   logic [2:0] core_state;
   logic       rd, wr;
   logic [7:0] rs, rt;
   logic       mem_read_valid, mem_write_valid, mem_ready;
   logic [7:0] mem_read_address, mem_write_address, mem_write_data, mem_read_data;
   logic [1:0] lsu_state;
   logic [7:0] lsu_out;
   logic       lsu_error;
   int checks = 0;
   int errors = 0;
`ifdef LSU_TIMEOUT_EN
   localparam int TC = 4;
`else
   localparam int TC = 64;
`endif
   lsu_frontend #(.ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(TC)) dut (
      .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
      .decoded_mem_read_enable(rd), .decoded_mem_write_enable(wr), .rs(rs), .rt(rt),
      .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
      .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
      .mem_write_data(mem_write_data), .mem_ready(mem_ready), .mem_read_data(mem_read_data),
      .lsu_state(lsu_state), .lsu_out(lsu_out), .lsu_error(lsu_error)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   initial begin
      reset = 0; enable = 0; core_state = 0; rd = 0; wr = 0; rs = 0; rt = 0;
      mem_ready = 0; mem_read_data = 0;
      #3;
      chk("rst_state", lsu_state, 0);
      chk("rst_rv", mem_read_valid, 0);
      chk("rst_wv", mem_write_valid, 0);
      chk("rst_out", lsu_out, 0);
      chk("rst_err", lsu_error, 0);
      chk("rst_wd", mem_write_data, 0);
      @(negedge clk); reset = 1;
      step;
      chk("post_rst_idle", lsu_state, 0);
      // load
      enable = 1; core_state = 3'b011; rd = 1; rs = 8'h2A;
      step;
      chk("ld_req_state", lsu_state, 1);
      chk("ld_req_rv", mem_read_valid, 1);
      chk("ld_req_ra", mem_read_address, 8'h2A);
      chk("ld_req_wv", mem_write_valid, 0);
      core_state = 0; rd = 0; rs = 8'h00;
      step;
      chk("ld_w1_state", lsu_state, 2);
      chk("ld_w1_rv", mem_read_valid, 1);
      step;
      chk("ld_w2_state", lsu_state, 2);
      chk("ld_w2_ra", mem_read_address, 8'h2A);
      mem_ready = 1; mem_read_data = 8'h5C;
      step;
      chk("ld_done_state", lsu_state, 3);
      chk("ld_done_rv", mem_read_valid, 0);
      chk("ld_done_out", lsu_out, 8'h5C);
      mem_ready = 0;
      step;
      chk("ld_done_hold", lsu_state, 3);
      core_state = 3'b110;
      step;
      chk("ld_idle", lsu_state, 0);
      // stray ready in IDLE
      core_state = 0; mem_ready = 1; mem_read_data = 8'h11;
      step;
      chk("stray_idle_state", lsu_state, 0);
      chk("stray_idle_out", lsu_out, 8'h5C);
      mem_ready = 0;
      // store
      core_state = 3'b011; wr = 1; rs = 8'h10; rt = 8'h99;
      step;
      chk("st_req_state", lsu_state, 1);
      chk("st_req_wv", mem_write_valid, 1);
      chk("st_req_wa", mem_write_address, 8'h10);
      chk("st_req_wd", mem_write_data, 8'h99);
      chk("st_req_rv", mem_read_valid, 0);
      core_state = 0; wr = 0; rs = 0; rt = 0;
      step;
      chk("st_w1_wv", mem_write_valid, 1);
      chk("st_w1_wa", mem_write_address, 8'h10);
      chk("st_w1_wd", mem_write_data, 8'h99);
      chk("st_w1_rv", mem_read_valid, 0);
      step;
      chk("st_w2_state", lsu_state, 2);
      mem_ready = 1; mem_read_data = 8'hEE;
      step;
      chk("st_done_state", lsu_state, 3);
      chk("st_done_wv", mem_write_valid, 0);
      chk("st_done_out", lsu_out, 8'h5C);
      mem_read_data = 8'h33;
      step;
      chk("stray_done_state", lsu_state, 3);
      chk("stray_done_out", lsu_out, 8'h5C);
      mem_ready = 0; core_state = 3'b110;
      step;
      chk("st_idle", lsu_state, 0);
      // both decodes
      core_state = 3'b011; rd = 1; wr = 1; rs = 8'h07; rt = 8'h44;
      step;
      chk("both_rv", mem_read_valid, 1);
      chk("both_ra", mem_read_address, 8'h07);
      chk("both_wv", mem_write_valid, 0);
      core_state = 0; rd = 0; wr = 0;
      step;
      chk("both_w_wv", mem_write_valid, 0);
      mem_ready = 1; mem_read_data = 8'hA1;
      step;
      chk("both_out", lsu_out, 8'hA1);
      chk("both_done", lsu_state, 3);
      mem_ready = 0; core_state = 3'b110;
      step;
      chk("both_idle", lsu_state, 0);
      // reset on 3rd WAITING cycle
      core_state = 3'b011; rd = 1; rs = 8'h55;
      step;
      core_state = 0; rd = 0;
      step; step; step;
      chk("rw_w3_state", lsu_state, 2);
      chk("rw_w3_rv", mem_read_valid, 1);
      #2 reset = 0;
      #1;
      chk("rw_async_rv", mem_read_valid, 0);
      chk("rw_async_state", lsu_state, 0);
      chk("rw_async_out", lsu_out, 0);
      @(negedge clk); reset = 1;
      mem_ready = 1; mem_read_data = 8'h77;
      step;
      chk("rw_late_state", lsu_state, 0);
      chk("rw_late_out", lsu_out, 0);
      mem_ready = 0;
      // enable low in IDLE
      enable = 0; core_state = 3'b011; rd = 1; rs = 8'h20;
      step;
      chk("en_low_state", lsu_state, 0);
      chk("en_low_rv", mem_read_valid, 0);
      // enable dropping in flight
      enable = 1;
      step;
      chk("en_req", lsu_state, 1);
      enable = 0; core_state = 0; rd = 0;
      step;
      chk("en_drop_state", lsu_state, 2);
      chk("en_drop_rv", mem_read_valid, 1);
      mem_ready = 1; mem_read_data = 8'h3C;
      step;
      chk("en_drop_out", lsu_out, 8'h3C);
      mem_ready = 0; core_state = 3'b110;
      step;
      chk("en_drop_idle", lsu_state, 0);
      enable = 1;
`ifdef LSU_TIMEOUT_EN
      core_state = 3'b011; rd = 1; rs = 8'h61;
      step;
      core_state = 0; rd = 0;
      step; step; step; step;
      chk("to_w4_state", lsu_state, 2);
      chk("to_w4_rv", mem_read_valid, 1);
      chk("to_w4_err", lsu_error, 0);
      step;
      chk("to_state", lsu_state, 3);
      chk("to_rv", mem_read_valid, 0);
      chk("to_err", lsu_error, 1);
      chk("to_out", lsu_out, 8'h3C);
      core_state = 3'b110;
      step;
      core_state = 3'b011; rd = 1; rs = 8'h62;
      step;
      core_state = 0; rd = 0;
      step;
      mem_ready = 1; mem_read_data = 8'hB7;
      step;
      mem_ready = 0;
      chk("to_next_out", lsu_out, 8'hB7);
      chk("to_sticky_err", lsu_error, 1);
`else
      core_state = 3'b011; rd = 1; rs = 8'h61;
      step;
      core_state = 0; rd = 0;
      repeat (80) step;
      chk("nto_state", lsu_state, 2);
      chk("nto_rv", mem_read_valid, 1);
      chk("nto_err", lsu_error, 0);
      mem_ready = 1; mem_read_data = 8'hB7;
      step;
      mem_ready = 0;
      chk("nto_out", lsu_out, 8'hB7);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
